alu_seq: RTL

- Parametrised, registered successor to the processor's combinational ALU.
- Adds a valid/ready input handshake and a registered result.
- Extends the operation set: XOR, shifts, set-less-than, plus an optional iterative multiplier.
- Sits between the register-file read stage and writeback; the control unit stalls issue while in_ready is low.

---
 rtl/alu_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input handshake.
// `define ALU_MUL_EN to build the iterative MUL/MULHU unit.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             ovf_f
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of two >= 8");
  end
  if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4) ||
      (WIDTH % MUL_STEP) != 0) begin : g_bad_step
    $error("alu_seq: MUL_STEP must be 1, 2 or 4 and divide WIDTH");
  end

  logic             accept;
  logic             is_mul;
  logic             sub_op;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign accept = in_valid && in_ready;
  assign shamt  = b[SHW-1:0];

  // Adder shared by ADD and SUB; SUB inverts B and injects the carry.
  always_comb begin
    sub_op = (sel == OP_SUB);
    bx     = sub_op ? ~b : b;
    sum    = a + bx + WIDTH'(sub_op);
  end

  // Single-cycle result and overflow for the selected operation.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (sel)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD,
      OP_SUB: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == bx[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN

  localparam int NSTEP = WIDTH / MUL_STEP;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      cnt_q;
  logic               last;
  logic               mul_hi_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mul_val;

  assign is_mul   = (sel == OP_MUL) || (sel == OP_MULH);
  assign in_ready = (state_q == IDLE);
  assign last     = (cnt_q == CW'(NSTEP - 1));

  // Shift-add: retire MUL_STEP multiplier bits into the product.
  always_comb begin
    prod_d = prod_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) begin
        prod_d = prod_d + (mcand_q << i);
      end
    end
    mul_val = mul_hi_q ? prod_d[2*WIDTH-1:WIDTH]
                       : prod_d[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> MUL on a multiply, MUL -> DONE on the last step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiplier operands, partial product and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mul_hi_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (accept && is_mul) begin
      cnt_q    <= '0;
      mul_hi_q <= (sel == OP_MULH);
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
    end else if (state_q == MUL) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      prod_q   <= prod_d;
    end
  end

  // Output registers: single-cycle ops on accept, multiply on its
  // final step so out_valid is high during DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      zero_f    <= 1'b1;
      ovf_f     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        result    <= alu_res;
        zero_f    <= ~|alu_res;
        ovf_f     <= alu_ovf;
        out_valid <= 1'b1;
      end else if (state_q == MUL && last) begin
        result    <= mul_val;
        zero_f    <= ~|mul_val;
        ovf_f     <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

`else

  assign is_mul   = 1'b0;
  assign in_ready = 1'b1;

  // Output registers: every accepted op completes in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= '0;
      zero_f    <= 1'b1;
      ovf_f     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        result    <= alu_res;
        zero_f    <= ~|alu_res;
        ovf_f     <= alu_ovf;
        out_valid <= 1'b1;
      end
    end
  end

`endif

endmodule
